// File: rtl/poly_small_gen_if.sv
// Sample-in / coefficient-out stream bundle for poly_small_gen.
// master = generator side, slave = sampler/consumer side.
interface poly_small_gen_if #(
    parameter int SW   = 7,
    parameter int LOGN = 9,
    parameter int PW   = 1
);
    logic            samp_valid;
    logic            samp_ready;
    logic [SW-1:0]   samp_val;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_coef;
    logic [LOGN-1:0] out_idx;
    logic [PW-1:0]   out_poly;
    logic            out_last;

    modport master (
        input  samp_valid,
        input  samp_val,
        input  out_ready,
        output samp_ready,
        output out_valid,
        output out_coef,
        output out_idx,
        output out_poly,
        output out_last
    );

    modport slave (
        output samp_valid,
        output samp_val,
        output out_ready,
        input  samp_ready,
        input  out_valid,
        input  out_coef,
        input  out_idx,
        input  out_poly,
        input  out_last
    );
endinterface

// File: rtl/poly_small_gen.sv
// Small-polynomial generator: parity-enforced coefficient stream with
// saturating squared-norm accumulation and a 2-entry output FIFO.
module poly_small_gen #(
    parameter int LOGN       = 9,
    parameter int NPOLY      = 2,
    parameter int SW         = 7,
    parameter int NW         = 24,
    parameter int NORM_BOUND = 16822
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    poly_small_gen_if.master io,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] norm_sq,
    output logic          norm_ok,
    output logic [15:0]   rej_cnt
);
    localparam int PW = (NPOLY > 2) ? $clog2(NPOLY) : 1;
    localparam int AW = ((NW > 2*SW) ? NW : 2*SW) + 1;
    localparam int CW = (NW > 31) ? NW + 1 : 32;
    localparam logic [AW-1:0] NMAX =
        {{(AW-NW){1'b0}}, {NW{1'b1}}};
    localparam logic [CW-1:0] BOUND = CW'(NORM_BOUND);
    localparam logic [PW-1:0] PLAST = PW'(NPOLY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [SW-1:0]   coef;
        logic [LOGN-1:0] idx;
        logic [PW-1:0]   poly;
        logic            last;
    } ent_t;

    state_t          state;
    state_t          state_nx;
    ent_t            mem [2];
    ent_t            head;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      cnt;
    logic [LOGN-1:0] idx;
    logic [PW-1:0]   poly;
    logic            parity;

    logic            acc;
    logic            last_idx;
    logic            last_poly;
    logic            pass;
    logic            push;
    logic            rej;
    logic            pop;
    logic            fin;

    logic [2*SW-1:0] sx;
    logic [2*SW-1:0] sq;
    logic [AW-1:0]   sum;
    logic [NW-1:0]   norm_nx;

    assign io.samp_ready = (state == S_RUN) && (cnt != 2'd2);
    assign io.out_valid  = (cnt != 2'd0);

    assign head         = mem[rd_ptr];
    assign io.out_coef  = head.coef;
    assign io.out_idx   = head.idx;
    assign io.out_poly  = head.poly;
    assign io.out_last  = head.last;

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    assign acc       = io.samp_valid && io.samp_ready && !abort;
    assign last_idx  = (idx == {LOGN{1'b1}});
    assign last_poly = (poly == PLAST);
    assign pass      = parity ^ io.samp_val[0];
    assign push      = acc && (!last_idx || pass);
    assign rej       = acc && last_idx && !pass;
    assign pop       = io.out_valid && io.out_ready;
    assign fin       = push && last_idx && last_poly;

    // Low 2*SW bits of the unsigned square equal the signed square.
    assign sx  = {{SW{io.samp_val[SW-1]}}, io.samp_val};
    assign sq  = sx * sx;
    assign sum = {{(AW-NW){1'b0}}, norm_sq}
               + {{(AW-2*SW){1'b0}}, sq};
    assign norm_nx = (sum > NMAX) ? {NW{1'b1}} : sum[NW-1:0];

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (fin) state_nx = S_DRAIN;
            S_DRAIN: if (cnt == 2'd0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            cnt     <= 2'd0;
            idx     <= '0;
            poly    <= '0;
            parity  <= 1'b0;
            norm_sq <= '0;
            norm_ok <= 1'b0;
            rej_cnt <= '0;
        end else if (abort) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if ((state == S_IDLE) && start) begin
                idx     <= '0;
                poly    <= '0;
                parity  <= 1'b0;
                norm_sq <= '0;
                norm_ok <= 1'b0;
                rej_cnt <= '0;
            end
            if (push) begin
                mem[wr_ptr] <= '{
                    coef: io.samp_val,
                    idx:  idx,
                    poly: poly,
                    last: last_idx && last_poly
                };
                wr_ptr  <= !wr_ptr;
                idx     <= idx + 1'b1;
                norm_sq <= norm_nx;
                parity  <= last_idx ? 1'b0 : pass;
                if (last_idx)
                    poly <= last_poly ? '0 : poly + 1'b1;
            end
            if (rej && (rej_cnt != 16'hFFFF))
                rej_cnt <= rej_cnt + 16'd1;
            if (pop) rd_ptr <= !rd_ptr;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: ;
            endcase
            // Norm is frozen once draining, so the verdict latches here.
            if ((state == S_DRAIN) && (cnt == 2'd0))
                norm_ok <= ({{(CW-NW){1'b0}}, norm_sq} <= BOUND);
        end
    end
endmodule

// File: tb/tb_poly_small_gen.sv
// Directed bench for poly_small_gen: three instances that differ only
// in norm bound / norm width, driven in lockstep.
module tb_poly_small_gen;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       sv;
    logic [6:0] sval;
    logic       ordy;

    int checks;
    int failures;
    int cyc_n;
    int done_cnt;
    int done_cyc;
    int last_cyc;

    logic [10:0] q[$];
    logic [10:0] eq[$];

    poly_small_gen_if #(.SW(7), .LOGN(2), .PW(1)) i0 ();
    poly_small_gen_if #(.SW(7), .LOGN(2), .PW(1)) i1 ();
    poly_small_gen_if #(.SW(7), .LOGN(2), .PW(1)) i2 ();

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [23:0] nsq0, nsq1;
    logic [7:0]  nsq2;
    logic        ok0, ok1, ok2;
    logic [15:0] rej0, rej1, rej2;

    assign i0.samp_valid = sv;
    assign i1.samp_valid = sv;
    assign i2.samp_valid = sv;
    assign i0.samp_val   = sval;
    assign i1.samp_val   = sval;
    assign i2.samp_val   = sval;
    assign i0.out_ready  = ordy;
    assign i1.out_ready  = ordy;
    assign i2.out_ready  = ordy;

    poly_small_gen #(.LOGN(2), .NPOLY(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .io(i0), .busy(busy0), .done(done0), .norm_sq(nsq0),
        .norm_ok(ok0), .rej_cnt(rej0)
    );

    poly_small_gen #(.LOGN(2), .NPOLY(2), .NORM_BOUND(7687)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .io(i1), .busy(busy1), .done(done1), .norm_sq(nsq1),
        .norm_ok(ok1), .rej_cnt(rej1)
    );

    poly_small_gen #(.LOGN(2), .NPOLY(2), .NW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .io(i2), .busy(busy2), .done(done2), .norm_sq(nsq2),
        .norm_ok(ok2), .rej_cnt(rej2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] ent(input int c, input int i,
                                        input int p, input int l);
        return {7'(c), 2'(i), 1'(p), 1'(l)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && i0.out_valid && i0.out_ready) begin
            q.push_back({i0.out_coef, i0.out_idx,
                         i0.out_poly, i0.out_last});
            if (i0.out_last) last_cyc = cyc_n;
        end
        if (rst_n && done0) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
    end

    // u1/u2 differ only in norm handling, so all else must match u0.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("lock_u1",
                {1'b0, i1.out_valid, i1.samp_ready, i1.out_last,
                 i1.out_poly, i1.out_idx, i1.out_coef, busy1, done1, rej1},
                {1'b0, i0.out_valid, i0.samp_ready, i0.out_last,
                 i0.out_poly, i0.out_idx, i0.out_coef, busy0, done0, rej0});
            chk("lock_u2",
                {1'b0, i2.out_valid, i2.samp_ready, i2.out_last,
                 i2.out_poly, i2.out_idx, i2.out_coef, busy2, done2, rej2},
                {1'b0, i0.out_valid, i0.samp_ready, i0.out_last,
                 i0.out_poly, i0.out_idx, i0.out_coef, busy0, done0, rej0});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send(input int v);
        int t;
        t = 0;
        sv = 1'b1;
        sval = 7'(v);
        while (!i0.samp_ready && t < 50) begin
            cyc();
            t++;
        end
        chk("send_timeout", 32'(t < 50), 32'd1);
        cyc();
        sv = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done0 && t < 50) begin
            cyc();
            t++;
        end
        chk("done_timeout", 32'(t < 50), 32'd1);
    endtask

    task automatic wait_q(input int n);
        int t;
        t = 0;
        while (q.size() < n && t < 50) begin
            cyc();
            t++;
        end
        chk("q_timeout", 32'(t < 50), 32'd1);
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_n"}, q.size(), eq.size());
        for (int i = 0; i < eq.size() && i < q.size(); i++)
            chk(tag, 32'(q[i]), 32'(eq[i]));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_srdy"}, 32'(i0.samp_ready), 32'd0);
        chk({tag, "_oval"}, 32'(i0.out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_ok"}, 32'(ok0), 32'd0);
        chk({tag, "_last"}, 32'(i0.out_last), 32'd0);
        chk({tag, "_norm"}, 32'(nsq0), 32'd0);
        chk({tag, "_rej"}, 32'(rej0), 32'd0);
        chk({tag, "_coef"}, 32'(i0.out_coef), 32'd0);
        chk({tag, "_idx"}, 32'(i0.out_idx), 32'd0);
        chk({tag, "_poly"}, 32'(i0.out_poly), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc_n = 0;
        done_cnt = 0;
        done_cyc = 0;
        last_cyc = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sv = 1'b0;
        sval = '0;
        ordy = 1'b1;

        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        cyc();

        // Basic run with one parity rejection
        q.delete();
        done_cnt = 0;
        pulse_start();
        chk("run_busy", 32'(busy0), 32'd1);
        chk("run_srdy", 32'(i0.samp_ready), 32'd1);
        send(1); send(1); send(0); send(2); send(-1);
        send(1); send(0); send(0); send(0);
        wait_done();
        chk("b_norm", 32'(nsq0), 32'd4);
        chk("b_ok", 32'(ok0), 32'd1);
        chk("b_rej", 32'(rej0), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("b_done_1cyc", 32'(done0), 32'd0);
        chk("b_start_ign", 32'(busy0), 32'd0);
        chk("b_done_cnt", 32'(done_cnt), 32'd1);
        chk("b_done_gap", 32'(done_cyc - last_cyc), 32'd2);
        eq.delete();
        eq.push_back(ent(1, 0, 0, 0));
        eq.push_back(ent(1, 1, 0, 0));
        eq.push_back(ent(0, 2, 0, 0));
        eq.push_back(ent(-1, 3, 0, 0));
        eq.push_back(ent(1, 0, 1, 0));
        eq.push_back(ent(0, 1, 1, 0));
        eq.push_back(ent(0, 2, 1, 0));
        eq.push_back(ent(0, 3, 1, 1));
        cmp_q("b_out");
        chk("b_norm_hold", 32'(nsq0), 32'd4);

        // Large coefficients: 6*961 + 2*1024 = 7814
        q.delete();
        pulse_start();
        chk("n_norm_clr", 32'(nsq0), 32'd0);
        send(31); send(-31); send(31); send(-32);
        send(31); send(-31); send(31); send(-31); send(-32);
        wait_done();
        chk("n_norm0", 32'(nsq0), 32'd7814);
        chk("n_ok0", 32'(ok0), 32'd1);
        chk("n_norm1", 32'(nsq1), 32'd7814);
        chk("n_ok1", 32'(ok1), 32'd0);
        chk("n_norm2", 32'(nsq2), 32'd255);
        chk("n_rej", 32'(rej0), 32'd1);
        chk("n_last", 32'(q[7]), 32'(ent(-32, 3, 1, 1)));
        cyc();

        // Saturation: 2*(3*225 + 196) = 1742, 8-bit sticks at 255
        q.delete();
        pulse_start();
        send(15); send(15); send(15); send(14);
        send(15); send(15); send(15); send(14);
        wait_done();
        chk("s_norm0", 32'(nsq0), 32'd1742);
        chk("s_norm2", 32'(nsq2), 32'd255);
        chk("s_ok2", 32'(ok2), 32'd1);
        chk("s_ok1", 32'(ok1), 32'd1);
        chk("s_rej", 32'(rej0), 32'd0);
        cyc();

        // Backpressure
        q.delete();
        ordy = 1'b0;
        pulse_start();
        send(5); send(6);
        sv = 1'b1;
        sval = 7'd7;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_srdy", 32'(i0.samp_ready), 32'd0);
            chk("bp_oval", 32'(i0.out_valid), 32'd1);
            chk("bp_head", {i0.out_coef, i0.out_idx, i0.out_poly},
                {7'd5, 2'd0, 1'b0});
        end
        ordy = 1'b1;
        send(7); send(1);
        wait_q(4);
        eq.delete();
        eq.push_back(ent(5, 0, 0, 0));
        eq.push_back(ent(6, 1, 0, 0));
        eq.push_back(ent(7, 2, 0, 0));
        eq.push_back(ent(1, 3, 0, 0));
        cmp_q("bp_out");

        // Abort with FIFO full in poly 1
        ordy = 1'b0;
        done_cnt = 0;
        send(2); send(3);
        chk("ab_full", 32'({i0.out_valid, i0.samp_ready}), 32'b10);
        chk("ab_poly", 32'(i0.out_poly), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("ab_oval", 32'(i0.out_valid), 32'd0);
        chk("ab_busy", 32'(busy0), 32'd0);
        repeat (3) cyc();
        chk("ab_nodone", 32'(done_cnt), 32'd0);
        ordy = 1'b1;

        // Clean run after abort, then async reset in DRAIN
        q.delete();
        pulse_start();
        send(9); send(2); send(2); send(2);
        send(1); send(2); send(2);
        ordy = 1'b0;
        send(2);
        chk("dr_busy", 32'(busy0), 32'd1);
        chk("dr_srdy", 32'(i0.samp_ready), 32'd0);
        chk("dr_oval", 32'(i0.out_valid), 32'd1);
        chk("dr_first", 32'(q.size() > 0 ? q[0] : 11'h7FF),
            32'(ent(9, 0, 0, 0)));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        #3;
        rst_n = 1'b1;
        cyc();
        ordy = 1'b1;
        q.delete();
        pulse_start();
        chk("post_busy", 32'(busy0), 32'd1);
        send(4);
        wait_q(1);
        chk("post_out", 32'(q[0]), 32'(ent(4, 0, 0, 0)));
        chk("post_norm", 32'(nsq0), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
